// File: rtl/plic_irq_pkg.sv
// Shared definitions for the PLIC interrupt front-end: filter width default,
// counter type and the level/edge mode encoding used by PLIC integration.
package plic_irq_pkg;

  localparam int unsigned FILT_W_DEFAULT = 4;

  typedef logic [FILT_W_DEFAULT-1:0] filt_cnt_t;

  localparam logic LE_LEVEL = 1'b0;
  localparam logic LE_EDGE  = 1'b1;

endpackage

// File: rtl/plic_irq_conditioner_if.sv
// Bundle of per-source interrupt lines, configuration and conditioned outputs
// between the device side and the PLIC front-end.
interface plic_irq_conditioner_if
  import plic_irq_pkg::*;
#(
  parameter int unsigned N_SOURCE = 30,
  parameter int unsigned FILT_W   = FILT_W_DEFAULT
);

  logic [N_SOURCE-1:0] irq_raw_i;
  logic [N_SOURCE-1:0] pol_i;
  logic [N_SOURCE-1:0] le_cfg_i;
  logic [FILT_W-1:0]   filt_cyc_i;
  logic [N_SOURCE-1:0] irq_o;
  logic [N_SOURCE-1:0] le_o;

  modport master (
    output irq_raw_i, pol_i, le_cfg_i, filt_cyc_i,
    input  irq_o, le_o
  );

  modport slave (
    input  irq_raw_i, pol_i, le_cfg_i, filt_cyc_i,
    output irq_o, le_o
  );

endinterface

// File: rtl/plic_irq_filter.sv
// One interrupt source: synchroniser, polarity correction, stability filter
// and level/edge output former.
module plic_irq_filter
  import plic_irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = FILT_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              raw_i,
  input  logic              pol_i,
  input  logic              le_i,
  input  logic [FILT_W-1:0] filt_cyc_i,
  output logic              irq_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   f_q;
  logic                   f_d_q;
  logic [FILT_W-1:0]      cnt_q;

  // Reset preloads the polarity so an idle active-low line reads inactive.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{pol_i}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ pol_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      f_q   <= 1'b0;
      f_d_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      f_d_q <= f_q;
      if (s == f_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= filt_cyc_i) begin
        f_q   <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + {{(FILT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign irq_o = (le_i == LE_EDGE) ? (f_q & ~f_d_q) : f_q;

endmodule

// File: rtl/plic_irq_conditioner.sv
// PLIC interrupt front-end: one filter per source plus the registered mode
// vector, so mode and data reach the PLIC on the same clock boundary.
module plic_irq_conditioner
  import plic_irq_pkg::*;
#(
  parameter int unsigned N_SOURCE    = 30,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = FILT_W_DEFAULT
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  plic_irq_conditioner_if.slave         bus
);

  logic [N_SOURCE-1:0] le_q;
  logic [N_SOURCE-1:0] irq_w;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      le_q <= '0;
    end else begin
      le_q <= bus.le_cfg_i;
    end
  end

  for (genvar k = 0; k < N_SOURCE; k++) begin : g_src
    plic_irq_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_filter (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .raw_i      (bus.irq_raw_i[k]),
      .pol_i      (bus.pol_i[k]),
      .le_i       (le_q[k]),
      .filt_cyc_i (bus.filt_cyc_i),
      .irq_o      (irq_w[k])
    );
  end

  assign bus.le_o  = le_q;
  assign bus.irq_o = irq_w;

endmodule

// File: tb/tb_plic_irq_conditioner.sv
// Directed bench for plic_irq_conditioner: reset behaviour, filter thresholds,
// edge pulses, simultaneous sources and mode switching.
module tb_plic_irq_conditioner;
  import plic_irq_pkg::*;

  localparam int unsigned NS = 30;
  localparam logic [NS-1:0] ALL_ONES = {NS{1'b1}};
  localparam logic [NS-1:0] LE_PAT   = 30'h2AAA_AAAA;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  plic_irq_conditioner_if #(.N_SOURCE(NS), .FILT_W(FILT_W_DEFAULT)) bus ();

  plic_irq_conditioner #(
    .N_SOURCE    (NS),
    .SYNC_STAGES (2),
    .FILT_W      (FILT_W_DEFAULT)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.irq_raw_i  = '0;
    bus.pol_i      = '0;
    bus.le_cfg_i   = '0;
    bus.filt_cyc_i = '0;
    bus.irq_raw_i[3] = 1'b1;
    bus.pol_i[3]     = 1'b1;
    step(3);
    checks++;
    if (bus.irq_o !== '0) begin
      failures++;
      $display("FAIL reset_irq actual=%h required=%h", bus.irq_o, {NS{1'b0}});
    end
    checks++;
    if (bus.le_o !== '0) begin
      failures++;
      $display("FAIL reset_le actual=%h required=%h", bus.le_o, {NS{1'b0}});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      checks++;
      if (bus.irq_o[3] !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle_active_low cycle=%0d actual=%b required=0", i, bus.irq_o[3]);
      end
    end
  endtask

  task automatic test_level();
    logic [2:0] exp_rise;
    logic [2:0] exp_fall;
    exp_rise = 3'b100;
    exp_fall = 3'b011;
    bus.filt_cyc_i = 4'd0;
    bus.irq_raw_i[0] = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step(1);
      checks++;
      if (bus.irq_o[0] !== exp_rise[e]) begin
        failures++;
        $display("FAIL level_rise edge=%0d actual=%b required=%b", e + 1, bus.irq_o[0], exp_rise[e]);
      end
    end
    bus.irq_raw_i[0] = 1'b0;
    for (int e = 0; e < 3; e++) begin
      step(1);
      checks++;
      if (bus.irq_o[0] !== exp_fall[e]) begin
        failures++;
        $display("FAIL level_fall edge=%0d actual=%b required=%b", e + 1, bus.irq_o[0], exp_fall[e]);
      end
    end
  endtask

  task automatic test_filter();
    int seen;
    bus.filt_cyc_i = 4'd5;
    // 5-cycle pulse: one short of the accepted width
    bus.irq_raw_i[1] = 1'b1;
    step(5);
    bus.irq_raw_i[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.irq_o[1] === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL filter_short_pulse high_cycles=%0d required=0", seen);
    end
    // 6-cycle pulse: asserts at edge 8
    bus.irq_raw_i[1] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      if (e == 7) bus.irq_raw_i[1] = 1'b0;
      step(1);
      checks++;
      if (bus.irq_o[1] !== (e == 8)) begin
        failures++;
        $display("FAIL filter_min_pulse edge=%0d actual=%b required=%b", e, bus.irq_o[1], (e == 8));
      end
    end
    step(20);
    checks++;
    if (bus.irq_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL filter_release actual=%b required=0", bus.irq_o[1]);
    end
    // threshold lowered while the counter holds 4
    bus.irq_raw_i[1] = 1'b1;
    step(6);
    checks++;
    if (bus.irq_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL filter_before_lower actual=%b required=0", bus.irq_o[1]);
    end
    bus.filt_cyc_i = 4'd2;
    step(1);
    checks++;
    if (bus.irq_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL filter_lowered_threshold actual=%b required=1", bus.irq_o[1]);
    end
    bus.irq_raw_i[1] = 1'b0;
    step(10);
    bus.filt_cyc_i = 4'd0;
  endtask

  task automatic test_edge();
    int highs;
    int first;
    bus.le_cfg_i[2] = LE_EDGE;
    step(1);
    checks++;
    if (bus.le_o[2] !== 1'b1) begin
      failures++;
      $display("FAIL edge_le_o actual=%b required=1", bus.le_o[2]);
    end
    bus.irq_raw_i[2] = 1'b1;
    highs = 0;
    first = -1;
    for (int e = 1; e <= 20; e++) begin
      step(1);
      if (bus.irq_o[2] === 1'b1) begin
        highs++;
        if (first < 0) first = e;
      end
    end
    checks++;
    if (highs != 1) begin
      failures++;
      $display("FAIL edge_single_pulse high_cycles=%0d required=1", highs);
    end
    checks++;
    if (first != 3) begin
      failures++;
      $display("FAIL edge_pulse_latency edge=%0d required=3", first);
    end
    bus.irq_raw_i[2] = 1'b0;
    step(2);
    bus.irq_raw_i[2] = 1'b1;
    highs = 0;
    for (int e = 1; e <= 12; e++) begin
      step(1);
      if (bus.irq_o[2] === 1'b1) highs++;
    end
    checks++;
    if (highs != 1) begin
      failures++;
      $display("FAIL edge_retrigger high_cycles=%0d required=1", highs);
    end
    bus.irq_raw_i[2] = 1'b0;
    step(5);
  endtask

  task automatic test_simultaneous();
    bus.pol_i     = '0;
    bus.irq_raw_i = '0;
    bus.le_cfg_i  = LE_PAT;
    step(10);
    checks++;
    if (bus.irq_o !== '0) begin
      failures++;
      $display("FAIL simul_idle actual=%h required=%h", bus.irq_o, {NS{1'b0}});
    end
    checks++;
    if (bus.le_o !== LE_PAT) begin
      failures++;
      $display("FAIL simul_le_o actual=%h required=%h", bus.le_o, LE_PAT);
    end
    bus.irq_raw_i = ALL_ONES;
    step(2);
    checks++;
    if (bus.irq_o !== '0) begin
      failures++;
      $display("FAIL simul_edge2 actual=%h required=%h", bus.irq_o, {NS{1'b0}});
    end
    step(1);
    checks++;
    if (bus.irq_o !== ALL_ONES) begin
      failures++;
      $display("FAIL simul_edge3 actual=%h required=%h", bus.irq_o, ALL_ONES);
    end
    step(1);
    checks++;
    if (bus.irq_o !== ~LE_PAT) begin
      failures++;
      $display("FAIL simul_edge4 actual=%h required=%h", bus.irq_o, ~LE_PAT);
    end
    bus.irq_raw_i = '0;
    step(10);
  endtask

  task automatic test_mode_switch();
    int highs;
    bus.le_cfg_i = '0;
    bus.irq_raw_i[4] = 1'b1;
    step(5);
    checks++;
    if (bus.irq_o[4] !== 1'b1) begin
      failures++;
      $display("FAIL mode_level_high actual=%b required=1", bus.irq_o[4]);
    end
    bus.le_cfg_i[4] = LE_EDGE;
    highs = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (bus.irq_o[4] === 1'b1) highs++;
    end
    checks++;
    if (highs != 0) begin
      failures++;
      $display("FAIL mode_level_to_edge high_cycles=%0d required=0", highs);
    end
    bus.le_cfg_i[4] = LE_LEVEL;
    #1;
    checks++;
    if (bus.irq_o[4] !== 1'b0) begin
      failures++;
      $display("FAIL mode_edge_to_level_early actual=%b required=0", bus.irq_o[4]);
    end
    step(1);
    checks++;
    if (bus.irq_o[4] !== 1'b1) begin
      failures++;
      $display("FAIL mode_edge_to_level actual=%b required=1", bus.irq_o[4]);
    end
    bus.irq_raw_i[4] = 1'b0;
    step(5);
  endtask

  task automatic test_reset_midfilter();
    bus.filt_cyc_i = 4'd5;
    bus.irq_raw_i[5] = 1'b1;
    step(5);
    rst_n = 1'b0;
    step(1);
    checks++;
    if (bus.irq_o !== '0) begin
      failures++;
      $display("FAIL midreset_irq actual=%h required=%h", bus.irq_o, {NS{1'b0}});
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step(1);
      checks++;
      if (bus.irq_o[5] !== (e == 8)) begin
        failures++;
        $display("FAIL midreset_restart edge=%0d actual=%b required=%b", e, bus.irq_o[5], (e == 8));
      end
    end
    bus.irq_raw_i[5] = 1'b0;
    step(10);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_level();
    test_filter();
    test_edge();
    test_simultaneous();
    test_mode_switch();
    test_reset_midfilter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
